func_sweep_ctrl: RTL
====================

// Module: func_sweep_ctrl
// PURPOSE
//   Sequencer for exhaustive checking of N-input single-output combinational functions.
//   On start, steps the shared select/input bus through every code 0..2^N-1.
//   Two implementations (e.g. mux-based and gate-based) are driven in parallel.
//   Their outputs are captured into truth-table registers, and each vector is
//   scored against a golden table. Replaces hand-written per-function sweep loops
//   with one synthesizable, reusable checker.
// PARAMETERS
//   N       3            function input count; sweep length = 2^N vectors
//   SETTLE  1            cycles sel is held before sampling; legal range >= 1
//   EXPECT  8'b00111001  golden truth table, width 2^N; EXPECT[i] = f(sel==i)
// PORTS
//   clk          in   1      clock, rising edge
//   reset        in   1      asynchronous, active-high reset
//   start        in   1      begin a sweep; sampled only in IDLE
//   y_a          in   1      output of implementation A under sel
//   y_b          in   1      output of implementation B under sel
//   sel          out  N      input vector driven to both implementations, {a,b,c} MSB-first
//   busy         out  1      high from the cycle after start is accepted until DONE exits
//   done         out  1      one-cycle pulse at sweep end
//   table_a      out  2^N    captured truth table of A, bit i = y_a at sel==i
//   table_b      out  2^N    captured truth table of B
//   err_count    out  N+1    number of bad vectors in the sweep (0..2^N)
//   first_bad    out  N      index of the lowest bad vector; 0 when none
//   first_bad_v  out  1      first_bad is valid
//   pass         out  1      err_count==0; valid while done pulses and held until next start
// BEHAVIOUR
//   Reset (async, any state): state=IDLE and all outputs 0 (sel, busy, done, tables,
//     err_count, first_bad, first_bad_v, pass). The wait counter is also cleared.
//   All outputs are registered. Outputs are decoded only from state and registers,
//     never combinationally from inputs.
//   FSM states: IDLE, SETTLE, SAMPLE, DONE.
//     IDLE  : if start, then on the next edge:
//             - sel=0, tables=0, err_count=0, first_bad_v=0, pass=0
//             - wait=SETTLE-1, go to SETTLE
//     SETTLE: hold sel; if wait==0 go to SAMPLE, else wait--
//     SAMPLE: on this edge:
//             - table_a[sel]<=y_a, table_b[sel]<=y_b
//             - vector is bad if y_a!=EXPECT[sel] or y_b!=EXPECT[sel]
//             - if bad: err_count++; if !first_bad_v: first_bad<=sel, first_bad_v<=1
//             - if sel==2^N-1 go to DONE, else sel++, wait=SETTLE-1, go to SETTLE
//     DONE  : done=1 for exactly this one cycle; pass=(err_count==0); go to IDLE.
//             sel returns to 0 on exit.
//   Timing:
//     - Each vector occupies SETTLE+1 cycles: SETTLE cycles holding sel, then 1 SAMPLE cycle.
//     - Latency: done is high in the cycle beginning 2^N*(SETTLE+1)+1 edges after
//       the edge that sampled start. Default = 17.
//   Boundaries:
//     - start while busy or in DONE: ignored, with no restart and no queuing.
//     - start held high continuously: a new sweep begins on the edge after DONE.
//     - sel wrap: the last vector 2^N-1 ends the sweep; sel never wraps to 0 mid-sweep.
//     - err_count saturates naturally at 2^N (width N+1), with no overflow.
//     - Results persist in IDLE until the next accepted start clears them.
//     - reset mid-sweep: immediate abort, no done pulse. A later start runs a full
//       clean sweep.
// TESTING
//   1. A=B=correct f (table 00111001), start pulse:
//      -> table_a=table_b=8'h39, err_count=0, pass=1, done on edge 17.
//   2. B stuck-at-0, A correct:
//      -> table_b=8'h00, err_count=4 (vectors 0,3,4,5), first_bad=0, first_bad_v=1, pass=0.
//   3. A inverted only at sel==5:
//      -> table_a=8'h19, err_count=1, first_bad=5, pass=0.
//   4. start re-pulsed at edges 3 and 10 of a sweep:
//      -> ignored; single done at edge 17; sel sequence 0..7 each held 2 cycles.
//   5. reset asserted while sel==4:
//      -> all outputs 0 asynchronously, no done. New start gives case-1 results at edge 17.
//   6. SETTLE=3, start held high:
//      -> done at edge 33, next sweep busy one edge after DONE, results cleared then rebuilt.

Source files
------------

// File: rtl/func_sweep_ctrl.sv
// rtl/func_sweep_ctrl.sv - exhaustive sweep checker for two N-input single-output functions
//
// Purpose:
//   On an accepted start, drives sel through every code 0..2^N-1. Each code is
//   held for SETTLE cycles and then sampled for one cycle. Both implementation
//   outputs are captured into truth tables, and each vector is scored against
//   the golden table EXPECT.
//
// Ports:
//   clk          in   1      clock, rising edge
//   reset        in   1      asynchronous, active-high reset
//   start        in   1      begin a sweep (only looked at in IDLE)
//   y_a, y_b     in   1      outputs of implementations A and B for the current sel
//   sel          out  N      vector driven to both implementations
//   busy         out  1      sweep in progress (cleared when DONE exits)
//   done         out  1      one-cycle pulse at sweep end
//   table_a/b    out  2^N    captured truth tables, bit i = output at sel==i
//   err_count    out  N+1    number of bad vectors in the last sweep
//   first_bad    out  N      lowest bad vector index (0 when none)
//   first_bad_v  out  1      first_bad is valid
//   pass         out  1      err_count==0, updated with done and held until next start
module func_sweep_ctrl #(
  parameter int N = 3,
  parameter int SETTLE = 1,
  parameter logic [(1<<N)-1:0] EXPECT = 8'b00111001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              y_a,
  input  logic              y_b,
  output logic [N-1:0]      sel,
  output logic              busy,
  output logic              done,
  output logic [(1<<N)-1:0] table_a,
  output logic [(1<<N)-1:0] table_b,
  output logic [N:0]        err_count,
  output logic [N-1:0]      first_bad,
  output logic              first_bad_v,
  output logic              pass
);

  localparam int V  = 1 << N;
  localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [WW-1:0] W_INIT  = WW'(SETTLE - 1);
  localparam logic [WW-1:0] W_ONE   = WW'(1);
  localparam logic [WW-1:0] W_ZERO  = '0;
  localparam logic [N-1:0]  SEL_ONE = N'(1);
  localparam logic [N-1:0]  SEL_MAX = '1;
  localparam logic [N:0]    ERR_ONE = (N+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [WW-1:0]   r_wait;
  logic [N-1:0]    r_sel;
  logic            r_busy;
  logic            r_done;
  logic [V-1:0]    r_table_a;
  logic [V-1:0]    r_table_b;
  logic [N:0]      r_err_count;
  logic [N-1:0]    r_first_bad;
  logic            r_first_bad_v;
  logic            r_pass;

  logic            w_last;
  logic            w_exp;
  logic            w_bad;

  assign w_last = (r_sel == SEL_MAX);
  assign w_exp  = EXPECT[r_sel];
  assign w_bad  = (y_a != w_exp) || (y_b != w_exp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SETTLE;
      S_SETTLE: if (r_wait == W_ZERO) w_next = S_SAMPLE;
      S_SAMPLE: w_next = w_last ? S_DONE : S_SETTLE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait        <= '0;
      r_sel         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_table_a     <= '0;
      r_table_b     <= '0;
      r_err_count   <= '0;
      r_first_bad   <= '0;
      r_first_bad_v <= 1'b0;
      r_pass        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sel         <= '0;
            r_busy        <= 1'b1;
            r_wait        <= W_INIT;
            r_table_a     <= '0;
            r_table_b     <= '0;
            r_err_count   <= '0;
            r_first_bad   <= '0;
            r_first_bad_v <= 1'b0;
            r_pass        <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (r_wait != W_ZERO) r_wait <= r_wait - W_ONE;
        end
        S_SAMPLE: begin
          r_table_a[r_sel] <= y_a;
          r_table_b[r_sel] <= y_b;
          if (w_bad) begin
            // At most 2^N increments per sweep, so N+1 bits cannot overflow.
            r_err_count <= r_err_count + ERR_ONE;
            if (!r_first_bad_v) begin
              r_first_bad   <= r_sel;
              r_first_bad_v <= 1'b1;
            end
          end
          // The last vector ends the sweep; sel is never advanced past it.
          if (!w_last) begin
            r_sel  <= r_sel + SEL_ONE;
            r_wait <= W_INIT;
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_pass <= (r_err_count == '0);
          r_busy <= 1'b0;
          r_sel  <= '0;
        end
        default: begin
          r_sel  <= '0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign sel         = r_sel;
  assign busy        = r_busy;
  assign done        = r_done;
  assign table_a     = r_table_a;
  assign table_b     = r_table_b;
  assign err_count   = r_err_count;
  assign first_bad   = r_first_bad;
  assign first_bad_v = r_first_bad_v;
  assign pass        = r_pass;

endmodule
